// File: rtl/bt_config_pkg.sv
// Shared configuration for the fractional-delay filter: default word format,
// tap count, coefficient bank type and the identity reset bank.
package bt_config_pkg;
  localparam int BT_WL        = 16;
  localparam int BT_FRAC_BITS = 14;
  localparam int BT_FD_TAPS   = 6;

  typedef logic signed [BT_WL-1:0] bt_coef_t;
  typedef bt_coef_t [BT_FD_TAPS-1:0] bt_coef_arr_t;

  // Largest representable value below 1.0 for the given fractional bit count.
  function automatic logic [31:0] bt_unity(input int frac_bits);
    return (32'd1 << frac_bits) - 32'd1;
  endfunction

  localparam bt_coef_arr_t BT_FD_IDENTITY = bt_coef_arr_t'(bt_unity(BT_FRAC_BITS));
endpackage

// File: rtl/bt_fd_mac6.sv
// Six-tap multiply-accumulate: registered products, then a registered
// sum with round-half-up and saturation back to the sample word length.
module bt_fd_mac6
  import bt_config_pkg::*;
#(
  parameter int WL        = BT_WL,
  parameter int FRAC_BITS = BT_FRAC_BITS
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en_i,
  input  logic [BT_FD_TAPS-1:0][WL-1:0] x_i,
  input  logic [BT_FD_TAPS-1:0][WL-1:0] c_i,
  output logic [WL-1:0]                 y_o
);
  localparam int PW = 2 * WL;
  localparam int AW = 2 * WL + 3;
  localparam logic signed [AW-1:0] HALF = AW'(1) << (FRAC_BITS - 1);
  localparam logic signed [AW-1:0] MAXV = AW'((1 << (WL - 1)) - 1);
  localparam logic signed [AW-1:0] MINV = ~MAXV;

  logic signed [PW-1:0] prod_q [BT_FD_TAPS];
  logic signed [AW-1:0] acc_d;
  logic signed [AW-1:0] rnd_d;
  logic        [WL-1:0] y_d;
  logic        [WL-1:0] y_q;

  always_comb begin
    acc_d = '0;
    for (int i = 0; i < BT_FD_TAPS; i++) acc_d = acc_d + AW'(prod_q[i]);
    rnd_d = (acc_d + HALF) >>> FRAC_BITS;
    if (rnd_d > MAXV)      y_d = MAXV[WL-1:0];
    else if (rnd_d < MINV) y_d = MINV[WL-1:0];
    else                   y_d = rnd_d[WL-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BT_FD_TAPS; i++) prod_q[i] <= '0;
      y_q <= '0;
    end else if (en_i) begin
      for (int i = 0; i < BT_FD_TAPS; i++)
        prod_q[i] <= PW'($signed(x_i[i])) * PW'($signed(c_i[i]));
      y_q <= y_d;
    end
  end

  assign y_o = y_q;
endmodule

// File: rtl/bt_fd_filter.sv
// Streaming 6-tap fractional-delay filter with frame-aligned coefficient
// bank switching; three-stage pipeline stalled as a whole by output backpressure.
module bt_fd_filter
  import bt_config_pkg::*;
#(
  parameter int WL        = BT_WL,
  parameter int FRAC_BITS = BT_FRAC_BITS,
  parameter int ENABLE_FD = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [WL-1:0] s_data,
  input  logic          s_last,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [WL-1:0] m_data,
  output logic          m_last,
  input  logic          coef_we,
  input  logic [2:0]    coef_addr,
  input  logic [WL-1:0] coef_data,
  input  logic          coef_commit,
  output logic          coef_pending
);
  typedef logic [BT_FD_TAPS-1:0][WL-1:0] bank_t;
  localparam logic [WL-1:0] UNITY = WL'(bt_unity(FRAC_BITS));
  localparam bank_t         IDENT = bank_t'(UNITY);

  logic  en, accept, commit_req, copy;
  bank_t taps_q, coef1_q, shadow_q, active_q;
  logic  in_frame_q, pending_q;
  logic  v1_q, v2_q, v3_q, l1_q, l2_q, l3_q;
  logic  [WL-1:0] y;

  // Valid/ready: a beat transfers on an edge where valid && ready. The whole
  // pipeline advances only when the output is not stalled, so s_ready is
  // exactly that enable and depends combinationally on m_ready.
  assign en         = !(v3_q && !m_ready);
  assign s_ready    = en;
  assign accept     = s_valid && en;
  assign commit_req = coef_commit || pending_q;
  assign copy       = commit_req && ((accept && s_last) || !in_frame_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taps_q     <= '0;
      coef1_q    <= IDENT;
      in_frame_q <= 1'b0;
      {v1_q, v2_q, v3_q, l1_q, l2_q, l3_q} <= '0;
    end else if (en) begin
      v1_q <= accept;
      l1_q <= accept && s_last;
      v2_q <= v1_q;
      l2_q <= l1_q;
      v3_q <= v2_q;
      l3_q <= l2_q;
      if (accept) begin
        taps_q     <= in_frame_q ? {taps_q[BT_FD_TAPS-2:0], s_data} : bank_t'(s_data);
        // The sample travels with the bank that was active when it arrived,
        // so a frame-end switch never leaks into that frame's last output.
        coef1_q    <= (copy && !in_frame_q) ? shadow_q : active_q;
        in_frame_q <= !s_last;
      end else if (!in_frame_q) begin
        taps_q <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q  <= IDENT;
      active_q  <= IDENT;
      pending_q <= 1'b0;
    end else begin
      if (coef_we && coef_addr <= 3'd5) shadow_q[coef_addr] <= coef_data;
      if (copy) active_q <= shadow_q;
      pending_q <= commit_req && !copy;
    end
  end

  generate
    if (ENABLE_FD != 0) begin : g_fd
      bt_fd_mac6 #(.WL(WL), .FRAC_BITS(FRAC_BITS)) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (en),
        .x_i   (taps_q),
        .c_i   (coef1_q),
        .y_o   (y)
      );
      assign coef_pending = pending_q;
    end else begin : g_bypass
      logic [WL-1:0] d2_q, d3_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          d2_q <= '0;
          d3_q <= '0;
        end else if (en) begin
          d2_q <= taps_q[0];
          d3_q <= d2_q;
        end
      end
      assign y            = d3_q;
      assign coef_pending = 1'b0;
    end
  endgenerate

  assign m_valid = v3_q;
  assign m_data  = y;
  assign m_last  = l3_q;
endmodule
